// File: rtl/lut_eval_seq.sv
// lut_eval_seq: serially loaded N_IN-input truth table with single-cycle
// evaluation and a full-table sweep that counts the true minterms.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset (release is synchronised)
//   cfg_valid    a configuration bit is offered
//   cfg_bit      truth-table bit, minterm 0 first
//   cfg_ready    configuration bit accepted this cycle (IDLE/LOAD, out of reset)
//   tt_valid     a complete truth table is loaded
//   in_valid     evaluation request
//   in_vec       minterm index to evaluate, bit 0 = LSB
//   out_valid    one-cycle pulse, out_bit holds a result
//   out_bit      evaluation result (complemented when OUT_INV=1)
//   sweep_start  request a full-table sweep
//   busy         block is in LOAD or SWEEP
//   sweep_done   one-cycle pulse at sweep completion
//   ones_count   number of true minterms found by the last sweep
module lut_eval_seq #(
    parameter int N_IN    = 4,
    parameter bit OUT_INV = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            tt_valid,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    output logic            out_bit,
    input  logic            sweep_start,
    output logic            busy,
    output logic            sweep_done,
    output logic [N_IN:0]   ones_count
);
    localparam int TT_W = 2 ** N_IN;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t          state;
    logic [TT_W-1:0] tt;
    logic [N_IN-1:0] load_ptr;
    logic [N_IN-1:0] sweep_ptr;
    logic [N_IN:0]   acc;
    logic [N_IN:0]   acc_next;
    logic [1:0]      rst_sync;
    logic            rst_int_n;
    logic            cfg_acc;
    logic            eval_acc;

    // Assertion is immediate; release reaches the FSM only after two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // cfg_ready is held low until the synchronised reset releases so that
    // the handshake never reports an accept the FSM would not take.
    assign cfg_ready = rst_int_n && (state != SWEEP);
    assign busy      = (state != IDLE);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign eval_acc  = in_valid && (state == IDLE) && tt_valid;
    assign acc_next  = acc + {{N_IN{1'b0}}, tt[sweep_ptr]};

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            tt         <= '0;
            load_ptr   <= '0;
            sweep_ptr  <= '0;
            acc        <= '0;
            tt_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            sweep_done <= 1'b0;
            ones_count <= '0;
        end else begin
            out_valid  <= eval_acc;
            sweep_done <= 1'b0;
            // Reads the table as it stood before any write on this edge.
            if (eval_acc) out_bit <= tt[in_vec] ^ OUT_INV;
            case (state)
                IDLE: begin
                    if (cfg_acc) begin
                        tt[load_ptr] <= cfg_bit;
                        load_ptr     <= load_ptr + 1'b1;
                        tt_valid     <= 1'b0;
                        state        <= LOAD;
                    end else if (sweep_start && tt_valid) begin
                        sweep_ptr <= '0;
                        acc       <= '0;
                        state     <= SWEEP;
                    end
                end
                LOAD: begin
                    if (cfg_acc) begin
                        tt[load_ptr] <= cfg_bit;
                        load_ptr     <= load_ptr + 1'b1;
                        if (&load_ptr) begin
                            tt_valid <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                SWEEP: begin
                    acc       <= acc_next;
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (&sweep_ptr) begin
                        ones_count <= acc_next;
                        sweep_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_eval_seq.sv
// tb_lut_eval_seq: directed bench for lut_eval_seq, OUT_INV=0 and OUT_INV=1
// instances driven by the same stimulus.
module tb_lut_eval_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_vec = 4'd0;
    logic       sweep_start = 1'b0;

    logic       cfg_ready0, tt_valid0, out_valid0, out_bit0, busy0, sweep_done0;
    logic       cfg_ready1, tt_valid1, out_valid1, out_bit1, busy1, sweep_done1;
    logic [4:0] ones_count0, ones_count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lut_eval_seq #(.N_IN(4), .OUT_INV(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready0), .tt_valid(tt_valid0), .in_valid(in_valid),
        .in_vec(in_vec), .out_valid(out_valid0), .out_bit(out_bit0),
        .sweep_start(sweep_start), .busy(busy0), .sweep_done(sweep_done0),
        .ones_count(ones_count0)
    );

    lut_eval_seq #(.N_IN(4), .OUT_INV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready1), .tt_valid(tt_valid1), .in_valid(in_valid),
        .in_vec(in_vec), .out_valid(out_valid1), .out_bit(out_bit1),
        .sweep_start(sweep_start), .busy(busy1), .sweep_done(sweep_done1),
        .ones_count(ones_count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] w, input logic with_start);
        int sd = 0;
        for (int i = 0; i < 16; i++) begin
            cfg_valid   = 1'b1;
            cfg_bit     = w[i];
            sweep_start = with_start && (i == 0);
            step();
            sweep_start = 1'b0;
            if (sweep_done0) sd++;
            if (i == 0) begin
                check("load_busy_first", busy0, 1);
                check("load_tt_valid_cleared", tt_valid0, 0);
            end
            if (i == 14) check("load_tt_valid_pre16", tt_valid0, 0);
        end
        cfg_valid = 1'b0;
        check("load_tt_valid_16", tt_valid0, 1);
        check("load_tt_valid_16_inv", tt_valid1, 1);
        check("load_busy_end", busy0, 0);
        check("load_no_sweep_done", sd, 0);
    endtask

    task automatic eval(input logic [3:0] v, input logic e0, input logic e1);
        in_valid = 1'b1;
        in_vec   = v;
        step();
        check("eval_out_valid", out_valid0, 1);
        check("eval_out_bit", out_bit0, e0);
        check("eval_out_bit_inv", out_bit1, e1);
    endtask

    task automatic eval_stop();
        in_valid = 1'b0;
        step();
        check("eval_idle_out_valid", out_valid0, 0);
    endtask

    task automatic sweep(input logic [4:0] exp_cnt);
        int n = 0;
        int bad_rdy = 0;
        int bad_ov = 0;
        int sd = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        in_valid    = 1'b1;
        in_vec      = 4'd2;
        while (busy0 && n < 40) begin
            n++;
            if (cfg_ready0) bad_rdy++;
            if (out_valid0) bad_ov++;
            if (sweep_done0) sd++;
            step();
        end
        in_valid = 1'b0;
        check("sweep_busy_cycles", n, 16);
        check("sweep_cfg_ready_low", bad_rdy, 0);
        check("sweep_no_out_valid", bad_ov, 0);
        check("sweep_no_early_done", sd, 0);
        check("sweep_last_out_valid", out_valid0, 0);
        check("sweep_done_pulse", sweep_done0, 1);
        check("sweep_ones_count", ones_count0, exp_cnt);
        check("sweep_ones_count_inv", ones_count1, exp_cnt);
        check("sweep_cfg_ready_back", cfg_ready0, 1);
        step();
        check("sweep_done_once", sweep_done0, 0);
        check("sweep_count_held", ones_count0, exp_cnt);
    endtask

    initial begin
        int sd;
        repeat (3) step();
        check("rst_tt_valid", tt_valid0, 0);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_bit", out_bit1, 0);
        check("rst_sweep_done", sweep_done0, 0);
        check("rst_ones_count", ones_count0, 0);
        check("rst_busy", busy0, 0);

        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        rst_n     = 1'b1;
        step();
        check("sync_edge1_no_accept", busy0, 0);
        cfg_valid = 1'b0;
        repeat (3) step();

        in_valid = 1'b1;
        in_vec   = 4'd0;
        step();
        in_valid = 1'b0;
        check("eval_no_table", out_valid0, 0);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("sweep_no_table", busy0, 0);
        step();
        check("sweep_no_table_done", sweep_done0, 0);

        load(16'h8421, 1'b0);
        eval(4'd0, 1'b1, 1'b0);
        eval(4'd1, 1'b0, 1'b1);
        eval(4'd5, 1'b1, 1'b0);
        eval(4'd15, 1'b1, 1'b0);
        eval_stop();
        sweep(5'd4);

        load(16'hFFFF, 1'b0);
        sweep(5'd16);

        load(16'h0001, 1'b1);
        eval(4'd0, 1'b1, 1'b0);
        eval(4'd3, 1'b0, 1'b1);
        eval_stop();
        sweep(5'd1);

        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            step();
        end
        check("abort_mid_load_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        cfg_valid = 1'b0;
        check("abort_tt_valid", tt_valid0, 0);
        check("abort_out_valid", out_valid0, 0);
        check("abort_out_bit_inv", out_bit1, 0);
        check("abort_sweep_done", sweep_done0, 0);
        check("abort_ones_count", ones_count0, 0);
        check("abort_busy", busy0, 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("abort_sweep_ignored", busy0, 0);
        sd = 0;
        repeat (20) begin
            step();
            if (sweep_done0) sd++;
        end
        check("abort_no_sweep_done", sd, 0);
        in_valid = 1'b1;
        in_vec   = 4'd0;
        step();
        in_valid = 1'b0;
        check("abort_no_out_valid", out_valid0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
